lcd_transmitter: RTL and testbench

//  Downstream stage of the LCD configuration FSM. Serialises each 10-bit instruction word
//  {RS,RW,D[7:0]} onto the HD44780-style 4-bit LCD bus: upper nibble, then lower nibble.

---
 rtl/lcd_transmitter_if.sv | 27 ++
 rtl/lcd_transmitter.sv | 169 ++++++++++++++++
 tb/tb_lcd_transmitter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lcd_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_transmitter_if
//  Brief    : Request/instruction and 4-bit LCD bus bundle of lcd_transmitter.
//  Revision : 1.0
// ============================================================================
interface lcd_transmitter_if;
    logic       next_instruction;
    logic [9:0] db;
    logic       done;
    logic       busy;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] sf_d;

    modport master (
        output next_instruction, db,
        input  done, busy, lcd_e, lcd_rs, lcd_rw, sf_d
    );

    modport slave (
        input  next_instruction, db,
        output done, busy, lcd_e, lcd_rs, lcd_rw, sf_d
    );
endinterface
`default_nettype wire

// File: rtl/lcd_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_transmitter
//  Brief    : Serialises {RS,RW,D[7:0]} onto a 4-bit HD44780 bus, upper nibble
//             first, with E strobe timing and post-command wait, then pulses done.
//  Revision : 1.0
// ============================================================================
module lcd_transmitter #(
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 12,
    parameter int HOLD_CYC  = 1,
    parameter int GAP_CYC   = 50,
    parameter int WAIT_CYC  = 2000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    lcd_transmitter_if.slave  bus
);

    localparam int MAX_1 = (SETUP_CYC > E_CYC)    ? SETUP_CYC : E_CYC;
    localparam int MAX_2 = (MAX_1     > HOLD_CYC) ? MAX_1     : HOLD_CYC;
    localparam int MAX_3 = (MAX_2     > GAP_CYC)  ? MAX_2     : GAP_CYC;
    localparam int MAX_C = (MAX_3     > WAIT_CYC) ? MAX_3     : WAIT_CYC;
    localparam int CNT_W = $clog2(MAX_C) + 1;

    // Reload values: a state loaded with N-1 lasts exactly N cycles.
    localparam logic [CNT_W-1:0] RLD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] RLD_E     = CNT_W'(E_CYC - 1);
    localparam logic [CNT_W-1:0] RLD_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RLD_GAP   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RLD_WAIT  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LATCH   = 4'd1,
        U_SETUP = 4'd2,
        U_EN    = 4'd3,
        U_HOLD  = 4'd4,
        GAP     = 4'd5,
        L_SETUP = 4'd6,
        L_EN    = 4'd7,
        L_HOLD  = 4'd8,
        WAIT    = 4'd9,
        DONE    = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       db_q, db_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic             rw_q, rw_d;
    logic [3:0]       sf_q, sf_d;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;

    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CNT_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            db_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            sf_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            sf_q    <= sf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        case (state_q)
            IDLE: begin
                if (bus.next_instruction) state_d = LATCH;
            end
            LATCH: begin
                db_d    = bus.db;
                state_d = U_SETUP;
                cnt_d   = RLD_SETUP;
            end
            U_SETUP: begin
                if (cnt_zero) begin state_d = U_EN; cnt_d = RLD_E; end
                else cnt_d = cnt_dec;
            end
            U_EN: begin
                if (cnt_zero) begin state_d = U_HOLD; cnt_d = RLD_HOLD; end
                else cnt_d = cnt_dec;
            end
            U_HOLD: begin
                if (cnt_zero) begin state_d = GAP; cnt_d = RLD_GAP; end
                else cnt_d = cnt_dec;
            end
            GAP: begin
                if (cnt_zero) begin state_d = L_SETUP; cnt_d = RLD_SETUP; end
                else cnt_d = cnt_dec;
            end
            L_SETUP: begin
                if (cnt_zero) begin state_d = L_EN; cnt_d = RLD_E; end
                else cnt_d = cnt_dec;
            end
            L_EN: begin
                if (cnt_zero) begin state_d = L_HOLD; cnt_d = RLD_HOLD; end
                else cnt_d = cnt_dec;
            end
            L_HOLD: begin
                if (cnt_zero) begin state_d = WAIT; cnt_d = RLD_WAIT; end
                else cnt_d = cnt_dec;
            end
            WAIT: begin
                if (cnt_zero) begin state_d = DONE; cnt_d = '0; end
                else cnt_d = cnt_dec;
            end
            DONE: begin
                state_d = bus.next_instruction ? LATCH : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
        e_d    = (state_d == U_EN) || (state_d == L_EN);
        rs_d   = rs_q;
        rw_d   = rw_q;
        sf_d   = sf_q;
        if ((state_d == U_SETUP) || (state_d == U_EN) || (state_d == U_HOLD)) begin
            rs_d = db_d[9];
            rw_d = db_d[8];
            sf_d = db_d[7:4];
        end else if ((state_d == L_SETUP) || (state_d == L_EN) || (state_d == L_HOLD)) begin
            rs_d = db_d[9];
            rw_d = db_d[8];
            sf_d = db_d[3:0];
        end
    end

    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.lcd_e  = e_q;
    assign bus.lcd_rs = rs_q;
    assign bus.lcd_rw = rw_q;
    assign bus.sf_d   = sf_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_transmitter
//  Brief    : Scoreboard bench for lcd_transmitter: expected bus events are
//             queued at request time and matched as the DUT produces them.
//  Revision : 1.0
// ============================================================================
module tb_lcd_transmitter;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ndone = 0;
    logic mon_en = 1'b0;
    logic pe = 1'b0;
    logic pd = 1'b0;
    logic [31:0] sb_q[$];

    lcd_transmitter_if bus();

    lcd_transmitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    // Event word: {2'b0, kind[3:0], edge[19:0], rs, rw, sf_d[3:0]}
    // kind 1=E rise, 2=E fall, 3=done rise, 4=done fall
    function automatic logic [31:0] ev(input int kind, input int e,
                                       input logic [9:0] d, input bit low);
        logic [3:0] nib;
        nib = low ? d[3:0] : d[7:4];
        return {2'b00, kind[3:0], e[19:0], d[9], d[8], nib};
    endfunction

    task automatic observe(input int kind);
        logic [31:0] got;
        logic [31:0] exp;
        got = {2'b00, kind[3:0], cyc[19:0], bus.lcd_rs, bus.lcd_rw, bus.sf_d};
        if (sb_q.size() == 0) begin
            chk("unexpected_event", got, 32'h0);
        end else begin
            exp = sb_q.pop_front();
            chk("bus_event", got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.lcd_e === 1'b1 && pe !== 1'b1) observe(1);
            if (bus.lcd_e === 1'b0 && pe === 1'b1) observe(2);
            if (bus.done === 1'b1 && pd !== 1'b1) begin observe(3); ndone++; end
            if (bus.done === 1'b0 && pd === 1'b1) observe(4);
        end
        pe <= bus.lcd_e;
        pd <= bus.done;
    end

    // Called at a negedge; returns at the negedge after edge t0+1.
    task automatic send(input logic [9:0] d, input bit full, output int t0);
        bus.next_instruction = 1'b1;
        bus.db = d;
        t0 = cyc + 1;
        sb_q.push_back(ev(1, t0 + 3,  d, 1'b0));
        sb_q.push_back(ev(2, t0 + 15, d, 1'b0));
        if (full) begin
            sb_q.push_back(ev(1, t0 + 68,   d, 1'b1));
            sb_q.push_back(ev(2, t0 + 80,   d, 1'b1));
            sb_q.push_back(ev(3, t0 + 2081, d, 1'b1));
            sb_q.push_back(ev(4, t0 + 2082, d, 1'b1));
        end
        @(negedge clk);
        bus.next_instruction = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2400 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_left", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    function automatic logic [31:0] outs();
        return {22'h0, bus.done, bus.busy, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, 1'b0, bus.sf_d};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (cyc=%0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        logic [9:0] msg [17];
        reset = 1'b1;
        bus.next_instruction = 1'b0;
        bus.db = 10'h000;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", outs(), 32'h0);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_bus", outs(), 32'h0);

        // Instruction 0x28 (function set)
        send(10'h028, 1'b1, t0);
        chk("busy_after_accept", bus.busy, 1'b1);
        wait_drain();
        chk("busy_back_idle", bus.busy, 1'b0);

        // Data write 'C'
        send(10'h243, 1'b1, t0);
        wait_drain();

        // Ignored requests at edges 10 and 500, db disturbed after latch
        send(10'h1A5, 1'b1, t0);
        bus.db = 10'h3FF;
        repeat (8) @(negedge clk);
        bus.next_instruction = 1'b1;
        @(negedge clk);
        bus.next_instruction = 1'b0;
        repeat (489) @(negedge clk);
        bus.next_instruction = 1'b1;
        @(negedge clk);
        bus.next_instruction = 1'b0;
        wait_drain();
        chk("busy_after_ignored", bus.busy, 1'b0);

        // Reset during GAP
        send(10'h0C0, 1'b0, t0);
        repeat (38) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", outs(), 32'h0);
        reset = 1'b0;
        repeat (2200) @(negedge clk);
        chk("mid_reset_leftover", sb_q.size(), 32'd0);
        sb_q.delete();
        send(10'h0C0, 1'b1, t0);
        wait_drain();

        // Back-to-back: address + 16 characters, each request in the done cycle
        msg[0] = 10'h080;
        for (int i = 1; i < 17; i++) msg[i] = 10'h200 | (10'h40 + 10'(i));
        for (int i = 0; i < 17; i++) begin
            send(msg[i], 1'b1, t0);
            if (i < 16) repeat (2080) @(negedge clk);
        end
        wait_drain();
        chk("busy_end", bus.busy, 1'b0);
        chk("done_count", ndone, 32'd21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
